win33_tile: RTL and testbench

WIN33_TILE -- requirements
Module: win33_tile

---
 rtl/win33_tile.sv | 136 +++++++++++++
 tb/tb_win33_tile.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/win33_tile.sv
// 4x4 tile former for a 3x3 conv window: buffers four image rows
// and emits overlapping 4x4 tiles at stride 2 across each band.
module win33_tile #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int DW    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [DW-1:0]   pix_in,
  input  logic            pix_valid,
  output logic            pix_ready,
  output logic [4*DW-1:0] act1,
  output logic [4*DW-1:0] act2,
  output logic [4*DW-1:0] act3,
  output logic [4*DW-1:0] act4,
  output logic            tile_valid,
  input  logic            tile_ready,
  output logic            end_signal
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H) + 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] CS_LAST   = CW'(IMG_W - 4);
  localparam logic [RW-1:0] BAND_LAST = RW'((IMG_H - 2) / 2 - 1);

  typedef enum logic [1:0] {IDLE, FILL, EMIT, DONE} state_e;

  state_e state_q, state_d;

  logic [DW-1:0]   lb_q [4][IMG_W];
  logic [4*DW-1:0] act_q  [4];
  logic [4*DW-1:0] tile_d [4];
  logic [RW-1:0]   row_q, band_q, row_end;
  logic [CW-1:0]   col_q, cs_q, ncs;
  logic [1:0]      base, slot;
  logic            tv_q;
  logic            accept, col_wrap, tile_xfer;
  logic            last_tile, begin_frame;

  assign accept      = pix_valid & pix_ready;
  assign col_wrap    = col_q == COL_LAST;
  assign row_end     = {band_q[RW-2:0], 1'b0} + RW'(3);
  assign tile_xfer   = tv_q & tile_ready;
  assign last_tile   = tile_xfer & (cs_q == CS_LAST);
  assign begin_frame = (state_q == IDLE) & start;

  assign act1       = act_q[0];
  assign act2       = act_q[1];
  assign act3       = act_q[2];
  assign act4       = act_q[3];
  assign tile_valid = tv_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pix_ready  = 1'b0;
    end_signal = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = FILL;
      FILL: begin
        pix_ready = 1'b1;
        if (accept && col_wrap && row_q == row_end)
          state_d = EMIT;
      end
      EMIT: begin
        if (last_tile)
          state_d = (band_q == BAND_LAST) ? DONE : FILL;
      end
      DONE: begin
        end_signal = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Band b starts at image row 2b, i.e. slot (2b mod 4).
  always_comb begin
    ncs  = tv_q ? cs_q + CW'(2) : cs_q;
    base = {band_q[0], 1'b0};
    slot = '0;
    for (int r = 0; r < 4; r++) begin
      tile_d[r] = '0;
      slot = base + 2'(r);
      for (int c = 0; c < 4; c++)
        tile_d[r][DW*c +: DW] = lb_q[slot][ncs + CW'(c)];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) lb_q[row_q[1:0]][col_q] <= pix_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q  <= '0;
      col_q  <= '0;
      band_q <= '0;
      cs_q   <= '0;
      tv_q   <= 1'b0;
      for (int r = 0; r < 4; r++) act_q[r] <= '0;
    end else begin
      if (begin_frame) begin
        row_q  <= '0;
        col_q  <= '0;
        band_q <= '0;
        cs_q   <= '0;
      end
      if (accept) begin
        col_q <= col_wrap ? '0 : col_q + CW'(1);
        if (col_wrap) row_q <= row_q + RW'(1);
      end
      if (state_q == EMIT) begin
        if (!tv_q) begin
          act_q <= tile_d;
          tv_q  <= 1'b1;
        end else if (last_tile) begin
          tv_q   <= 1'b0;
          cs_q   <= '0;
          band_q <= band_q + RW'(1);
        end else if (tile_xfer) begin
          cs_q  <= cs_q + CW'(2);
          act_q <= tile_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_win33_tile.sv
// Directed bench for win33_tile: 4x4 and 28x28 frames, stalls,
// gapped pixels, stray start and mid-frame reset.
module tb_win33_tile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        tile_ready = 1'b0;
  logic        pix_ready, tile_valid, end_signal;
  logic [63:0] act1, act2, act3, act4;

  logic        s_start = 1'b0;
  logic [15:0] s_pix_in = '0;
  logic        s_pix_valid = 1'b0;
  logic        s_tile_ready = 1'b0;
  logic        s_pix_ready, s_tile_valid, s_end;
  logic [63:0] s_act1, s_act2, s_act3, s_act4;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  win33_tile dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .act1(act1), .act2(act2), .act3(act3), .act4(act4),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .end_signal(end_signal)
  );

  win33_tile #(.IMG_W(4), .IMG_H(4), .DW(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start),
    .pix_in(s_pix_in), .pix_valid(s_pix_valid),
    .pix_ready(s_pix_ready),
    .act1(s_act1), .act2(s_act2), .act3(s_act3), .act4(s_act4),
    .tile_valid(s_tile_valid), .tile_ready(s_tile_ready),
    .end_signal(s_end)
  );

  function automatic logic [255:0] exp_tile(int t);
    logic [255:0] v;
    logic [63:0]  rw;
    int b, k;
    b = t / 13;
    k = t % 13;
    v = '0;
    for (int r = 0; r < 4; r++) begin
      rw = '0;
      for (int c = 0; c < 4; c++)
        rw[16*c +: 16] = 16'((2*b + r)*32 + 2*k + c);
      v[64*(3-r) +: 64] = rw;
    end
    return v;
  endfunction

  function automatic logic [15:0] pix_val(int p);
    return 16'((p / 28)*32 + p % 28);
  endfunction

  task automatic test_reset();
    logic [5:0] st;
    st = {pix_ready, tile_valid, end_signal,
          s_pix_ready, s_tile_valid, s_end};
    n_tot++;
    if (st !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctl got=%b want=000000", st);
    end
    n_tot++;
    if ({act1, act2, act3, act4} !== 256'b0) begin
      n_bad++;
      $display("FAIL reset_act got=%h want=0", {act1, act2, act3, act4});
    end
  endtask

  task automatic test_small();
    int idx = 0;
    int cyc = 0;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    while (idx < 16 && cyc < 100) begin
      s_pix_valid = s_pix_ready;
      s_pix_in = 16'(idx);
      if (s_pix_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    s_pix_valid = 1'b0;
    n_tot++;
    if (idx != 16) begin
      n_bad++;
      $display("FAIL small_fill got=%0d want=16", idx);
    end
    n_tot++;
    if ({s_pix_ready, s_tile_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL small_emit_entry got=%b want=00",
               {s_pix_ready, s_tile_valid});
    end
    @(negedge clk);
    n_tot++;
    if (s_tile_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL small_tile_latency got=%b want=1", s_tile_valid);
    end
    n_tot++;
    if ({s_act1, s_act2, s_act3, s_act4} !==
        {64'h0003_0002_0001_0000, 64'h0007_0006_0005_0004,
         64'h000b_000a_0009_0008, 64'h000f_000e_000d_000c}) begin
      n_bad++;
      $display("FAIL small_tile got=%h", {s_act1, s_act2, s_act3, s_act4});
    end
    s_tile_ready = 1'b1;
    @(negedge clk);
    s_tile_ready = 1'b0;
    n_tot++;
    if ({s_tile_valid, s_end} !== 2'b01) begin
      n_bad++;
      $display("FAIL small_end got=%b want=01", {s_tile_valid, s_end});
    end
    @(negedge clk);
    n_tot++;
    if ({s_tile_valid, s_end} !== 2'b00) begin
      n_bad++;
      $display("FAIL small_end_pulse got=%b want=00", {s_tile_valid, s_end});
    end
  endtask

  task automatic run_frame(input bit rnd, input bit stall,
                           input bit poke, input int abort_at);
    int pidx = 0, tidx = 0, cyc = 0, stall_cnt = 0;
    bit pend = 0, fin = 0, hold = 0, aborted = 0;
    bit tr, pv;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!fin && cyc < 20000) begin
      cyc++;
      n_tot++;
      if (end_signal !== pend) begin
        n_bad++;
        $display("FAIL end_signal tile=%0d got=%b want=%b",
                 tidx, end_signal, pend);
      end
      if (pend) fin = 1;
      pend = 0;
      if (hold) begin
        n_tot++;
        if (tile_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL stall_hold tile=%0d got=%b want=1", tidx, tile_valid);
        end
      end
      hold = 0;
      if (!fin && abort_at >= 0 && tidx == abort_at && tile_valid) begin
        rst_n = 1'b0;
        pix_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          n_tot++;
          if ({pix_ready, tile_valid, end_signal} !== 3'b000) begin
            n_bad++;
            $display("FAIL abort_quiet got=%b want=000",
                     {pix_ready, tile_valid, end_signal});
          end
        end
        aborted = 1;
        fin = 1;
      end
      if (!fin) begin
        if (tile_valid) begin
          n_tot++;
          if (pix_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL emit_pix_ready got=%b want=0", pix_ready);
          end
          n_tot++;
          if ({act1, act2, act3, act4} !== exp_tile(tidx)) begin
            n_bad++;
            $display("FAIL tile%0d got=%h want=%h", tidx,
                     {act1, act2, act3, act4}, exp_tile(tidx));
          end
          tr = 1'b1;
          if (stall && tidx == 2 && stall_cnt < 5) begin
            tr = 1'b0;
            stall_cnt++;
            hold = 1;
          end
          tile_ready = tr;
          if (tr) begin
            tidx++;
            if (tidx == 169) pend = 1;
          end
        end else begin
          tile_ready = 1'b1;
        end
        pv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pidx >= 784) pv = 1'b0;
        pix_valid = pv;
        pix_in = pix_val(pidx);
        if (pv && pix_ready) pidx++;
        start = (poke && tile_valid && tidx == 20);
        @(negedge clk);
      end
    end
    start = 1'b0;
    pix_valid = 1'b0;
    if (!aborted) begin
      n_tot++;
      if (!fin || tidx != 169 || pidx != 784) begin
        n_bad++;
        $display("FAIL frame_count tiles=%0d pixels=%0d want=169/784",
                 tidx, pidx);
      end
      @(negedge clk);
      n_tot++;
      if ({end_signal, tile_valid, pix_ready} !== 3'b000) begin
        n_bad++;
        $display("FAIL end_once got=%b want=000",
                 {end_signal, tile_valid, pix_ready});
      end
    end
  endtask

  task automatic test_frame();
    run_frame(1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_stall();
    run_frame(1'b0, 1'b1, 1'b0, -1);
  endtask

  task automatic test_gaps_and_start();
    run_frame(1'b1, 1'b0, 1'b1, -1);
  endtask

  task automatic test_abort_restart();
    run_frame(1'b0, 1'b0, 1'b0, 28);
    run_frame(1'b0, 1'b1, 1'b0, -1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_small();
    test_frame();
    test_stall();
    test_gaps_and_start();
    test_abort_restart();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
